// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: bus widths, control levels, NOP encoding and the
// FETCH/HOLD/RST1 state encoding shared by the fetch stage files.
package if_fetch_pkg;

   localparam int InstAddrBus = 16;
   localparam int InstBus     = 16;

   localparam logic BranchFlagUp = 1'b1;
   localparam logic StallYes     = 1'b1;
   localparam logic RstEnable    = 1'b1;

   localparam logic [InstBus-1:0] OP_NOP = 16'h0800;

   typedef logic [InstAddrBus-1:0] addr_t;
   typedef logic [InstBus-1:0]     inst_t;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RST1  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic  valid;
      inst_t inst;
      addr_t pc;
   } if_id_t;

   function automatic addr_t pc_inc(input addr_t a);
      return a + addr_t'(1);
   endfunction

endpackage

// File: rtl/if_fetch_skid.sv
// if_fetch_skid: one-entry buffer for a fetched word that arrives
// while decode is stalled.
// Ports: clk, rst (sync, high); load captures word/word_pc;
// drain empties the entry; entry is the stored bundle (valid = full).
module if_fetch_skid
   import if_fetch_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   drain,
   input  inst_t  word,
   input  addr_t  word_pc,
   output if_id_t entry
);

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         entry <= '0;
      end else if (load) begin
         entry <= '{valid: 1'b1, inst: word, pc: word_pc};
      end else if (drain) begin
         entry.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with IF/ID output register,
// one-entry skid buffer and a single branch delay slot.
// Ports: clk, rst (sync, high); stall_i/stall_int_i hold outputs;
// branch_flag_i/branch_addr_i from decode; mem_req_o/mem_addr_o,
// mem_ack_i/mem_rdata_i to instruction memory; pc_o/inst_o/valid_o
// to decode (pc_o = fetch address + 1).
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter addr_t RESET_PC = 16'h0000,
   parameter inst_t NOP_INST = OP_NOP
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   stall_int_i,
   input  logic                   branch_flag_i,
   input  logic [InstAddrBus-1:0] branch_addr_i,
   output logic                   mem_req_o,
   output logic [InstAddrBus-1:0] mem_addr_o,
   input  logic                   mem_ack_i,
   input  logic [InstBus-1:0]     mem_rdata_i,
   output logic [InstAddrBus-1:0] pc_o,
   output logic [InstBus-1:0]     inst_o,
   output logic                   valid_o
);

   fetch_state_e state_q, state_d;
   addr_t        fpc_q, fpc_d;
   addr_t        raddr_q, raddr_d;
   logic         redir_q, redir_d;
   logic         hold, take, ack, park, drain;
   if_id_t       skid;

   assign hold  = (stall_i == StallYes) || (stall_int_i == StallYes);
   assign take  = valid_o && !hold && (branch_flag_i == BranchFlagUp);
   // acks outside FETCH (RST1 stale ack, HOLD) are ignored
   assign ack   = (state_q == ST_FETCH) && mem_ack_i;
   assign park  = ack && hold;
   assign drain = skid.valid && !hold;

   assign mem_req_o  = (state_q == ST_FETCH);
   assign mem_addr_o = fpc_q;

   if_fetch_skid u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (park),
      .drain   (drain),
      .word    (mem_rdata_i),
      .word_pc (pc_inc(fpc_q)),
      .entry   (skid)
   );

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         state_q == ST_RST1:  state_d = ST_FETCH;
         state_q == ST_FETCH: if (park) state_d = ST_HOLD;
         state_q == ST_HOLD:  if (!hold) state_d = ST_FETCH;
         default:             state_d = ST_RST1;
      endcase
   end

   always_comb begin
      fpc_d   = fpc_q;
      redir_d = redir_q;
      raddr_d = raddr_q;
      if (ack) begin
         fpc_d   = redir_q ? raddr_q : pc_inc(fpc_q);
         redir_d = 1'b0;
      end
      if (take) begin
         raddr_d = branch_addr_i;
         // delay slot already accepted (acked now or parked in
         // the skid): no request is open, so redirect at once
         if (ack || skid.valid) begin
            fpc_d   = branch_addr_i;
            redir_d = 1'b0;
         end else begin
            redir_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= ST_RST1;
         fpc_q   <= RESET_PC;
         raddr_q <= RESET_PC;
         redir_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         raddr_q <= raddr_d;
         redir_q <= redir_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         pc_o    <= RESET_PC;
         inst_o  <= NOP_INST;
         valid_o <= 1'b0;
      end else if (!hold) begin
         if (skid.valid) begin
            pc_o    <= skid.pc;
            inst_o  <= skid.inst;
            valid_o <= 1'b1;
         end else if (ack) begin
            pc_o    <= pc_inc(fpc_q);
            inst_o  <= mem_rdata_i;
            valid_o <= 1'b1;
         end else begin
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized bench for if_fetch with a
// queue-based fetch model and per-cycle output comparison.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst, stall_i, stall_int_i, branch_flag_i;
   logic [15:0] branch_addr_i, mem_rdata_i;
   logic        mem_ack_i;
   logic        mem_req_o, valid_o;
   logic [15:0] mem_addr_o, pc_o, inst_o;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .stall_int_i   (stall_int_i),
      .branch_flag_i (branch_flag_i),
      .branch_addr_i (branch_addr_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_rdata_i   (mem_rdata_i),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .valid_o       (valid_o)
   );

   localparam logic [15:0] NOP = 16'h0800;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] inst;
      logic [15:0] pc;
   } ent_t;

   // words fetched but not yet shown to decode
   ent_t        mq[$];
   logic        m_rst1, m_valid, m_pend;
   logic [15:0] m_fpc, m_pc, m_inst, m_tgt, m_ds;
   int          cool, waitst, wcnt;

   function automatic logic [15:0] memw(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   function automatic logic m_req();
      return !m_rst1 && (mq.size() == 0);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("mem_req", {15'd0, mem_req_o}, {15'd0, m_req()});
      chk("mem_addr", mem_addr_o, m_fpc);
      chk("pc", pc_o, m_pc);
      chk("inst", inst_o, m_inst);
      chk("valid", {15'd0, valid_o}, {15'd0, m_valid});
   endtask

   task automatic model_load(input ent_t e);
      m_inst  = e.inst;
      m_pc    = e.pc;
      m_valid = 1'b1;
      if (cool > 0) cool--;
   endtask

   // delay slot = word at the address after the branch (its pc_o);
   // redirect as soon as that word has been accepted
   task automatic model_step(input logic r, input logic hold,
                             input logic br, input logic [15:0] ba,
                             input logic acc);
      ent_t        w;
      logic        take, got;
      logic [15:0] nf;
      if (r) begin
         m_rst1 = 1'b1; m_fpc = 16'h0000; mq.delete();
         m_pc = 16'h0000; m_inst = NOP; m_valid = 1'b0;
         m_pend = 1'b0; cool = 0;
         return;
      end
      take   = m_valid && !hold && br;
      w.inst = memw(m_fpc);
      w.pc   = m_fpc + 16'd1;
      nf     = m_fpc;
      if (acc) begin
         nf = m_fpc + 16'd1;
         if (m_pend && m_fpc == m_ds) begin
            nf = m_tgt;
            m_pend = 1'b0;
         end
      end
      if (take) begin
         got = acc && (m_fpc == m_pc);
         foreach (mq[i]) if (mq[i].pc - 16'd1 == m_pc) got = 1'b1;
         if (got) nf = ba;
         else begin
            m_pend = 1'b1; m_tgt = ba; m_ds = m_pc;
         end
         cool = 2;
      end
      m_fpc  = nf;
      m_rst1 = 1'b0;
      if (!hold) begin
         if (mq.size() > 0) model_load(mq.pop_front());
         else if (acc) model_load(w);
         else begin
            m_inst = NOP; m_valid = 1'b0;
         end
      end else if (acc) begin
         mq.push_back(w);
      end
   endtask

   task automatic step(input logic r, st, sti, br,
                       input logic [15:0] ba, input logic stale);
      logic req, ack;
      check_outputs();
      req = m_req();
      if (stale) ack = 1'b1;
      else if (!req) ack = 1'b0;
      else if (waitst < 0) ack = ($urandom_range(0, 2) == 0);
      else ack = (wcnt >= waitst);
      rst           = r;
      stall_i       = st;
      stall_int_i   = sti;
      branch_flag_i = br;
      branch_addr_i = ba;
      mem_ack_i     = ack;
      mem_rdata_i   = stale ? 16'hDEAD : memw(m_fpc);
      model_step(r, st | sti, br, ba, req && ack);
      if (r || !req || ack) wcnt = 0;
      else wcnt++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int n;
      logic r, st, sti, br, stale;
      logic [15:0] ba;
      rst = 1'b1; stall_i = 1'b0; stall_int_i = 1'b0;
      branch_flag_i = 1'b0; branch_addr_i = 16'h0;
      mem_ack_i = 1'b0; mem_rdata_i = 16'h0;
      waitst = 0; wcnt = 0; cool = 0;
      model_step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_pc", pc_o, 16'h0000);
      chk("rst_inst", inst_o, 16'h0800);
      chk("rst_valid", {15'd0, valid_o}, 16'd0);
      chk("rst_req", {15'd0, mem_req_o}, 16'd0);
      chk("rst_addr", mem_addr_o, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

      // 0-wait straight line
      chk("rst1_req", {15'd0, mem_req_o}, 16'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
         chk("seq_pc", pc_o, 16'(k));
         chk("seq_valid", {15'd0, valid_o}, 16'd1);
      end

      // 2 wait states
      waitst = 2;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
         chk("ws_bubble", inst_o, 16'h0800);
         step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
         chk("ws_bubble_v", {15'd0, valid_o}, 16'd0);
         chk("ws_addr", mem_addr_o, 16'(4 + k));
         step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
         chk("ws_pc", pc_o, 16'(5 + k));
      end

      // stall 3 cycles, ack in the first
      waitst = 0;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
         chk("stall_pc", pc_o, 16'h0006);
         chk("stall_req", {15'd0, mem_req_o}, 16'd0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("drain_pc", pc_o, 16'h0007);
      chk("drain_inst", inst_o, memw(16'h0006));
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("post_drain_pc", pc_o, 16'h0008);

      // branch at addr 5 to 0x20
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("br_at5", pc_o, 16'h0006);
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 1'b0);
      chk("ds_pc", pc_o, 16'h0007);
      chk("ds_valid", {15'd0, valid_o}, 16'd1);
      chk("tgt_addr", mem_addr_o, 16'h0020);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("tgt_pc", pc_o, 16'h0021);

      // INT stall 1 cycle
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("int_pc", pc_o, 16'h0021);
      chk("int_inst", inst_o, memw(16'h0020));
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("int_next", pc_o, 16'h0022);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("int_next2", pc_o, 16'h0023);

      // wrap FFFF -> 0000
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
      chk("wrap_addr0", mem_addr_o, 16'hFFFE);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("wrap_addr1", mem_addr_o, 16'hFFFF);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("wrap_addr2", mem_addr_o, 16'h0000);
      chk("wrap_pc", pc_o, 16'h0000);

      // reset with fetch at FFFF in flight, stale ack after
      waitst = 3;
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      n = 0;
      while (!(m_req() && m_fpc == 16'hFFFF) && n < 20) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
         n++;
      end
      chk("inflight_addr", mem_addr_o, 16'hFFFF);
      chk("inflight_req", {15'd0, mem_req_o}, 16'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("stale_req", {15'd0, mem_req_o}, 16'd1);
      chk("stale_addr", mem_addr_o, 16'h0000);
      chk("stale_valid", {15'd0, valid_o}, 16'd0);
      chk("stale_inst", inst_o, 16'h0800);
      waitst = 0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("first_pc", pc_o, 16'h0001);
      chk("first_inst", inst_o, memw(16'h0000));

      // randomized
      for (int ph = 0; ph < 4; ph++) begin
         waitst = (ph == 1) ? 0 : (ph == 2) ? 2 : -1;
         repeat (1500) begin
            r   = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 4) == 0);
            sti = ($urandom_range(0, 19) == 0);
            if (m_valid) br = (cool == 0) && ($urandom_range(0, 5) == 0);
            else br = ($urandom_range(0, 1) == 1);
            stale = m_rst1 && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
               ba = 16'hFFFC + 16'($urandom_range(0, 3));
            else
               ba = 16'($urandom);
            step(r, st, sti, br, ba, stale);
         end
      end
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
